// File: rtl/commit_unit_pkg.sv
// Shared types for the commit stage: ROB head entry layout, instruction-type
// encoding and commit FSM state constants.
package commit_unit_pkg;

  localparam int CU_XLEN = 32;
  localparam int CU_RW   = 5;

  localparam logic [1:0] ITYPE_BRANCH = 2'b00;
  localparam logic [1:0] ITYPE_STORE  = 2'b01;
  localparam logic [1:0] ITYPE_ALU    = 2'b10;
  localparam logic [1:0] ITYPE_LOAD   = 2'b11;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_STORE_REQ = 2'd1;
  localparam logic [1:0] ST_FLUSH     = 2'd2;

  typedef struct packed {
    logic [1:0]         itype;
    logic [3:0]         ROB_number;
    logic               ready;
    logic [CU_XLEN-1:0] value;
    logic [CU_RW-1:0]   dest_reg;
    logic [CU_XLEN-1:0] addr;
    logic               branch_result;
    logic               pred_taken;
    logic [CU_XLEN-1:0] target;
  } ROB_entry_t;

endpackage

// File: rtl/commit_unit.sv
// In-order retirement stage: pops the ROB head, writes the register file,
// performs stores through a req/ack handshake and flushes on mispredicts.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int XLEN = CU_XLEN,
  parameter int RW   = CU_RW
) (
  input  logic             clk,
  input  logic             reset,
  input  ROB_entry_t       head,
  input  logic             head_valid,
  input  logic             head_ready,
  input  logic             ROB_head_store,
  output logic             rd_en,
  output logic             rf_wr_en,
  output logic [RW-1:0]    rf_wr_addr,
  output logic [XLEN-1:0]  rf_wr_data,
  output logic [3:0]       rf_wr_rob,
  output logic             mem_wr_req,
  output logic [XLEN-1:0]  mem_wr_addr,
  output logic [XLEN-1:0]  mem_wr_data,
  input  logic             mem_wr_ack,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [31:0]      retired_count
);

  logic [1:0] state;
  logic       committable;
  logic       pop;

  // The store flag duplicates itype and the entry's own ready bit duplicates
  // head_ready; commit decisions use itype and head_ready only.
  logic unused_head;
  assign unused_head = ^{head.ready, ROB_head_store};

  assign committable = head_valid && head_ready;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    pop = 1'b0;
    case (state)
      ST_IDLE:      pop = committable && (head.itype != ITYPE_STORE);
      ST_STORE_REQ: pop = mem_wr_ack;
      default:      pop = 1'b0;
    endcase
  end

  // A reset cycle never dequeues, even if a store ack arrives in it.
  assign rd_en = pop && !reset;

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      rf_wr_en      <= 1'b0;
      rf_wr_addr    <= '0;
      rf_wr_data    <= '0;
      rf_wr_rob     <= '0;
      mem_wr_req    <= 1'b0;
      mem_wr_addr   <= '0;
      mem_wr_data   <= '0;
      flush         <= 1'b0;
      redirect_pc   <= '0;
      retired_count <= '0;
    end else begin
      rf_wr_en <= 1'b0;
      flush    <= 1'b0;
      if (rd_en) retired_count <= retired_count + 32'd1;

      case (state)
        ST_IDLE: begin
          if (committable) begin
            case (head.itype)
              ITYPE_BRANCH: begin
                if (head.branch_result != head.pred_taken) begin
                  flush       <= 1'b1;
                  redirect_pc <= head.target;
                  state       <= ST_FLUSH;
                end
              end
              ITYPE_STORE: begin
                mem_wr_addr <= head.addr;
                mem_wr_data <= head.value;
                mem_wr_req  <= 1'b1;
                state       <= ST_STORE_REQ;
              end
              default: begin
                // x0 is hardwired: the entry retires but nothing is written.
                if (head.dest_reg != '0) begin
                  rf_wr_en   <= 1'b1;
                  rf_wr_addr <= head.dest_reg;
                  rf_wr_data <= head.value;
                  rf_wr_rob  <= head.ROB_number;
                end
              end
            endcase
          end
        end
        ST_STORE_REQ: begin
          if (mem_wr_ack) begin
            mem_wr_req <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: directed scenarios followed by random
// ROB traffic, all compared against a cycle-level reference model.
module tb_commit_unit;
  import commit_unit_pkg::*;

  logic        clk;
  logic        reset;
  ROB_entry_t  head;
  logic        head_valid, head_ready, ROB_head_store;
  logic        rd_en, rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [3:0]  rf_wr_rob;
  logic        mem_wr_req, mem_wr_ack, flush;
  logic [31:0] mem_wr_addr, mem_wr_data, redirect_pc, retired_count;

  commit_unit dut (
    .clk(clk), .reset(reset), .head(head), .head_valid(head_valid),
    .head_ready(head_ready), .ROB_head_store(ROB_head_store), .rd_en(rd_en),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_wr_rob(rf_wr_rob), .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack), .flush(flush),
    .redirect_pc(redirect_pc), .retired_count(retired_count)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the ROB contents as a queue plus what the retirement
  // stage is currently waiting on.
  ROB_entry_t  rob_q[$];
  bit          store_outstanding = 0;
  bit          flush_bubble      = 0;
  int unsigned m_count = 0;
  bit          e_rf_en, e_req, e_flush;
  logic [4:0]  e_rf_addr;
  logic [31:0] e_rf_data, e_maddr, e_mdata, e_redir;
  logic [3:0]  e_rob;

  function automatic ROB_entry_t rand_entry();
    ROB_entry_t e;
    e.itype         = 2'($urandom_range(3));
    e.ROB_number    = 4'($urandom_range(15));
    e.ready         = 1'b1;
    e.value         = $urandom;
    e.dest_reg      = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
    e.addr          = $urandom;
    e.branch_result = 1'($urandom_range(1));
    e.pred_taken    = 1'($urandom_range(1));
    e.target        = $urandom;
    return e;
  endfunction

  function automatic ROB_entry_t mk(input logic [1:0] it, input logic [4:0] rd,
                                    input logic [31:0] val, input logic [31:0] ad,
                                    input logic br, input logic pt, input logic [31:0] tg);
    ROB_entry_t e;
    e = rand_entry();
    e.itype = it; e.dest_reg = rd; e.value = val; e.addr = ad;
    e.branch_result = br; e.pred_taken = pt; e.target = tg;
    return e;
  endfunction

  // One clock: drive inputs, check the combinational pop before the edge,
  // advance the model across the edge and check registered outputs after it.
  task automatic run_cycle(input bit rdy, input bit ack, input bit rst, input bit vld);
    ROB_entry_t h;
    bit valid, commit, pop, mispredict;
    valid = (rob_q.size() != 0) && (vld || store_outstanding);
    h = valid ? rob_q[0] : rand_entry();
    reset = rst; head = h; head_valid = valid; head_ready = rdy;
    ROB_head_store = (h.itype == ITYPE_STORE); mem_wr_ack = ack;
    commit = valid && rdy;

    if (rst || flush_bubble) pop = 0;
    else if (store_outstanding) pop = ack;
    else pop = commit && (h.itype != ITYPE_STORE);

    @(negedge clk);
    check("rd_en", {31'd0, rd_en}, {31'd0, pop});
    @(posedge clk);
    #1;

    e_rf_en = 0; e_flush = 0;
    if (rst) begin
      e_req = 0; store_outstanding = 0; flush_bubble = 0; m_count = 0;
    end else begin
      if (pop) m_count++;
      if (flush_bubble) flush_bubble = 0;
      else if (store_outstanding) begin
        if (ack) begin
          store_outstanding = 0; e_req = 0;
          void'(rob_q.pop_front());
        end
      end else if (commit) begin
        if (h.itype == ITYPE_STORE) begin
          store_outstanding = 1; e_req = 1; e_maddr = h.addr; e_mdata = h.value;
        end else begin
          void'(rob_q.pop_front());
          mispredict = (h.itype == ITYPE_BRANCH) && (h.branch_result != h.pred_taken);
          if (mispredict) begin
            e_flush = 1; e_redir = h.target; flush_bubble = 1;
            rob_q.delete();  // younger, wrong-path entries are squashed
          end else if (h.itype != ITYPE_BRANCH && h.dest_reg != 0) begin
            e_rf_en = 1; e_rf_addr = h.dest_reg; e_rf_data = h.value; e_rob = h.ROB_number;
          end
        end
      end
    end

    check("rf_wr_en", {31'd0, rf_wr_en}, {31'd0, e_rf_en});
    if (e_rf_en) begin
      check("rf_wr_addr", {27'd0, rf_wr_addr}, {27'd0, e_rf_addr});
      check("rf_wr_data", rf_wr_data, e_rf_data);
      check("rf_wr_rob", {28'd0, rf_wr_rob}, {28'd0, e_rob});
    end
    check("mem_wr_req", {31'd0, mem_wr_req}, {31'd0, e_req});
    if (e_req) begin
      check("mem_wr_addr", mem_wr_addr, e_maddr);
      check("mem_wr_data", mem_wr_data, e_mdata);
    end
    check("flush", {31'd0, flush}, {31'd0, e_flush});
    if (e_flush) check("redirect_pc", redirect_pc, e_redir);
    check("retired_count", retired_count, m_count);
    if (rst) begin
      check("rst_rf_wr_addr", {27'd0, rf_wr_addr}, 32'd0);
      check("rst_rf_wr_data", rf_wr_data, 32'd0);
      check("rst_rf_wr_rob", {28'd0, rf_wr_rob}, 32'd0);
      check("rst_mem_wr_addr", mem_wr_addr, 32'd0);
      check("rst_mem_wr_data", mem_wr_data, 32'd0);
      check("rst_redirect_pc", redirect_pc, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; head = '0; head_valid = 0; head_ready = 0;
    ROB_head_store = 0; mem_wr_ack = 0;
    e_req = 0; e_rf_addr = 0; e_rf_data = 0; e_rob = 0;
    e_maddr = 0; e_mdata = 0; e_redir = 0;

    run_cycle(0, 0, 1, 0);
    run_cycle(1, 1, 1, 0);

    // ALU commit to x5
    rob_q.push_back(mk(ITYPE_ALU, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0));
    run_cycle(1, 0, 0, 1);
    run_cycle(0, 0, 0, 1);

    // Write to x0 still retires
    rob_q.push_back(mk(ITYPE_LOAD, 5'd0, 32'h1234, 0, 0, 0, 0));
    run_cycle(1, 0, 0, 1);

    // Head valid but not ready, and a stray ack in IDLE
    rob_q.push_back(mk(ITYPE_ALU, 5'd7, 32'h77, 0, 0, 0, 0));
    run_cycle(0, 1, 0, 1);
    run_cycle(1, 0, 0, 0);
    run_cycle(1, 0, 0, 1);

    // Store with ack three cycles after the request rises
    rob_q.push_back(mk(ITYPE_STORE, 5'd1, 32'h42, 32'h100, 0, 0, 0));
    run_cycle(1, 0, 0, 1);
    run_cycle(1, 0, 0, 1);
    run_cycle(1, 0, 0, 1);
    run_cycle(1, 1, 0, 1);
    run_cycle(0, 0, 0, 1);

    // Store acked in the first request cycle
    rob_q.push_back(mk(ITYPE_STORE, 5'd1, 32'h99, 32'h200, 0, 0, 0));
    run_cycle(1, 0, 0, 1);
    run_cycle(1, 1, 0, 1);

    // Mispredict, then a ready head during the flush cycle
    rob_q.push_back(mk(ITYPE_BRANCH, 5'd0, 0, 0, 1, 0, 32'h2000));
    run_cycle(1, 0, 0, 1);
    rob_q.push_back(mk(ITYPE_ALU, 5'd9, 32'hAAAA5555, 0, 0, 0, 0));
    run_cycle(1, 0, 0, 1);
    run_cycle(1, 0, 0, 1);

    // Correctly predicted branch followed by ALU, back to back
    rob_q.push_back(mk(ITYPE_BRANCH, 5'd0, 0, 0, 1, 1, 32'h3000));
    rob_q.push_back(mk(ITYPE_ALU, 5'd10, 32'h0BADF00D, 0, 0, 0, 0));
    run_cycle(1, 0, 0, 1);
    run_cycle(1, 0, 0, 1);

    // Reset arriving with an ack while a store is outstanding
    rob_q.push_back(mk(ITYPE_STORE, 5'd1, 32'h55, 32'h300, 0, 0, 0));
    run_cycle(1, 0, 0, 1);
    run_cycle(1, 0, 0, 1);
    run_cycle(1, 1, 1, 1);
    rob_q.delete();
    run_cycle(1, 1, 0, 1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if (rob_q.size() == 0) begin
        int n = $urandom_range(1, 4);
        for (int j = 0; j < n; j++) rob_q.push_back(rand_entry());
      end
      run_cycle($urandom_range(9) < 7, $urandom_range(9) < 4,
                $urandom_range(199) == 0, $urandom_range(9) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
